// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Brief    : Shared types and syndrome function for the Hamming(7,4)+parity
//            SECDED link (decoder RTL and encoder bench model).
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    typedef logic [7:0] codeword_t;
    typedef logic [3:0] message_t;
    typedef logic [2:0] syndrome_t;

    typedef enum logic [1:0] {
        ST_CLEAN       = 2'd0,
        ST_CORRECTED   = 2'd1,
        ST_PARITY_ONLY = 2'd2,
        ST_DOUBLE      = 2'd3
    } status_t;

    // Returns {s4,s2,s1}; nonzero value is the 1-based position of the bad bit.
    function automatic syndrome_t calc_syndrome(input codeword_t cw);
        calc_syndrome = {^{cw[3], cw[4], cw[5], cw[6]},
                         ^{cw[1], cw[2], cw[5], cw[6]},
                         ^{cw[0], cw[2], cw[4], cw[6]}};
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : hamming_syndrome
// Brief    : Combinational syndrome and overall-parity check of one codeword.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_syndrome
    import hamming_pkg::*;
(
    input  codeword_t i_cw,
    output syndrome_t o_syndrome,
    output logic      o_parity_err
);

    assign o_syndrome   = calc_syndrome(i_cw);
    assign o_parity_err = ^i_cw;

endmodule : hamming_syndrome
`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_decoder
// Brief    : 2-stage valid/ready SECDED decoder; optional saturating error
//            counters built only when HAM_ERR_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  codeword_t        in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output message_t         out_msg,
    output syndrome_t        out_syndrome,
    output status_t          out_status,
    output logic             out_corrected,
    output logic             out_ded,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] ded_cnt
);

    syndrome_t w_syn;
    logic      w_pe;
    logic      w_s1_ready;
    logic      w_s2_ready;

    logic      r_s1_v;
    codeword_t r_s1_cw;
    syndrome_t r_s1_syn;
    logic      r_s1_pe;

    logic      r_s2_v;
    message_t  r_s2_msg;
    syndrome_t r_s2_syn;
    status_t   r_s2_status;

    codeword_t w_fixed_cw;
    status_t   w_status;
    logic [3:0] w_unused_fixed_bits;

    hamming_syndrome u_syndrome (
        .i_cw         (in_cw),
        .o_syndrome   (w_syn),
        .o_parity_err (w_pe)
    );

    assign w_s2_ready = !r_s2_v || out_ready;
    assign w_s1_ready = !r_s1_v || w_s2_ready;
    assign in_ready   = w_s1_ready;

    always_comb begin
        w_fixed_cw = r_s1_cw;
        w_status   = ST_CLEAN;
        if (r_s1_syn != '0 && r_s1_pe) begin
            w_status   = ST_CORRECTED;
            w_fixed_cw = r_s1_cw ^ codeword_t'(8'd1 << (r_s1_syn - 3'd1));
        end else if (r_s1_syn == '0 && r_s1_pe) begin
            w_status = ST_PARITY_ONLY;
        end else if (r_s1_syn != '0) begin
            w_status = ST_DOUBLE;
        end
    end

    // Parity positions are dropped once the message has been extracted.
    assign w_unused_fixed_bits = {w_fixed_cw[7], w_fixed_cw[3], w_fixed_cw[1], w_fixed_cw[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else begin
            if (w_s1_ready) r_s1_v <= in_valid;
            if (w_s2_ready) r_s2_v <= r_s1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && w_s1_ready) begin
            r_s1_cw  <= in_cw;
            r_s1_syn <= w_syn;
            r_s1_pe  <= w_pe;
        end
        if (r_s1_v && w_s2_ready) begin
            r_s2_msg    <= {w_fixed_cw[6], w_fixed_cw[5], w_fixed_cw[4], w_fixed_cw[2]};
            r_s2_syn    <= r_s1_syn;
            r_s2_status <= w_status;
        end
    end

    assign out_valid     = r_s2_v;
    assign out_msg       = r_s2_v ? r_s2_msg : '0;
    assign out_syndrome  = r_s2_v ? r_s2_syn : '0;
    assign out_status    = r_s2_v ? r_s2_status : ST_CLEAN;
    assign out_corrected = r_s2_v && (r_s2_status == ST_CORRECTED || r_s2_status == ST_PARITY_ONLY);
    assign out_ded       = r_s2_v && (r_s2_status == ST_DOUBLE);

`ifdef HAM_ERR_STATS_EN
    logic             w_out_fire;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_ded_cnt;

    assign w_out_fire = r_s2_v && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_corr_cnt <= '0;
            r_ded_cnt  <= '0;
        end else if (stat_clr) begin
            r_corr_cnt <= '0;
            r_ded_cnt  <= '0;
        end else if (w_out_fire) begin
            if (out_corrected && r_corr_cnt != '1) r_corr_cnt <= r_corr_cnt + 1'b1;
            if (out_ded && r_ded_cnt != '1)        r_ded_cnt  <= r_ded_cnt + 1'b1;
        end
    end

    assign corr_cnt = r_corr_cnt;
    assign ded_cnt  = r_ded_cnt;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = stat_clr;
    assign corr_cnt          = '0;
    assign ded_cnt           = '0;
`endif

endmodule : hamming_secded_decoder
`default_nettype wire
